// File: rtl/time_bcd_formatter.sv
// Binary-to-BCD formatter for two display channels sharing one sequential
// double-dabble engine; each channel also gets a saturation flag and a blanking mask.
module time_bcd_formatter #(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned MAX_VAL = 9999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [IN_W-1:0]       a_bin,
  input  logic [IN_W-1:0]       b_bin,
  output logic [4*DIGITS-1:0]   a_bcd,
  output logic [4*DIGITS-1:0]   b_bcd,
  output logic                  a_ovf,
  output logic                  b_ovf,
  output logic [DIGITS-1:0]     a_blank,
  output logic [DIGITS-1:0]     b_blank,
  output logic                  a_valid,
  output logic                  b_valid
);

  // One spare digit so the full IN_W range converts before saturation.
  localparam int unsigned AccW = 4 * (DIGITS + 1);
  localparam int unsigned CntW = $clog2(IN_W + 1);
  localparam logic [IN_W-1:0] MaxValW = IN_W'(MAX_VAL);
  localparam logic [CntW-1:0] CntInit = CntW'(IN_W);

  typedef enum logic [1:0] {
    StLoad,
    StShift,
    StCommit
  } state_e;

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic [IN_W-1:0]     sr_q, sr_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                sat_q, sat_d;

  logic [4*DIGITS-1:0] a_bcd_q, a_bcd_d, b_bcd_q, b_bcd_d;
  logic                a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;
  logic [DIGITS-1:0]   a_blank_q, a_blank_d, b_blank_q, b_blank_d;
  logic                a_valid_q, a_valid_d, b_valid_q, b_valid_d;

  logic [IN_W-1:0]     sel_bin;
  logic [AccW-1:0]     acc_adj;
  logic [4*DIGITS-1:0] fin_digits;
  logic [DIGITS-1:0]   fin_blank;
  logic                all_zero;

  assign sel_bin = sel_q ? b_bin : a_bin;

  // Add-3 correction applied to every digit before each shift.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(DIGITS + 1); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Final digits after saturation, and the leading-zero mask derived from them.
  always_comb begin
    fin_digits = sat_q ? {DIGITS{4'h9}} : acc_q[4*DIGITS-1:0];
    fin_blank  = '0;
    all_zero   = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      all_zero     = all_zero & (fin_digits[4*i +: 4] == 4'd0);
      fin_blank[i] = all_zero;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    sr_d      = sr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    a_bcd_d   = a_bcd_q;
    b_bcd_d   = b_bcd_q;
    a_ovf_d   = a_ovf_q;
    b_ovf_d   = b_ovf_q;
    a_blank_d = a_blank_q;
    b_blank_d = b_blank_q;
    a_valid_d = a_valid_q;
    b_valid_d = b_valid_q;

    unique case (state_q)
      StLoad: begin
        if (en) begin
          sr_d    = sel_bin;
          acc_d   = '0;
          cnt_d   = CntInit;
          sat_d   = (sel_bin > MaxValW);
          state_d = StShift;
        end
      end
      StShift: begin
        {acc_d, sr_d} = {acc_adj[AccW-2:0], sr_q, 1'b0};
        cnt_d         = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        if (sel_q) begin
          b_bcd_d   = fin_digits;
          b_ovf_d   = sat_q;
          b_blank_d = fin_blank;
          b_valid_d = 1'b1;
        end else begin
          a_bcd_d   = fin_digits;
          a_ovf_d   = sat_q;
          a_blank_d = fin_blank;
          a_valid_d = 1'b1;
        end
        sel_d   = ~sel_q;
        state_d = StLoad;
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoad;
      sel_q     <= 1'b0;
      sr_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      a_bcd_q   <= '0;
      b_bcd_q   <= '0;
      a_ovf_q   <= 1'b0;
      b_ovf_q   <= 1'b0;
      a_blank_q <= '0;
      b_blank_q <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      sr_q      <= sr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      a_bcd_q   <= a_bcd_d;
      b_bcd_q   <= b_bcd_d;
      a_ovf_q   <= a_ovf_d;
      b_ovf_q   <= b_ovf_d;
      a_blank_q <= a_blank_d;
      b_blank_q <= b_blank_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
    end
  end

  assign a_bcd   = a_bcd_q;
  assign b_bcd   = b_bcd_q;
  assign a_ovf   = a_ovf_q;
  assign b_ovf   = b_ovf_q;
  assign a_blank = a_blank_q;
  assign b_blank = b_blank_q;
  assign a_valid = a_valid_q;
  assign b_valid = b_valid_q;

endmodule

// File: tb/tb_time_bcd_formatter.sv
// Bench for time_bcd_formatter: per-cycle comparison against an arithmetic model,
// directed literal checks, then randomized traffic with occasional resets.
module tb_time_bcd_formatter;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] a_bin, b_bin;
  logic [15:0] a_bcd, b_bcd;
  logic        a_ovf, b_ovf;
  logic [3:0]  a_blank, b_blank;
  logic        a_valid, b_valid;

  always #5 clk = ~clk;

  time_bcd_formatter #(
    .IN_W   (16),
    .DIGITS (4),
    .MAX_VAL(9999)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .a_bin  (a_bin),
    .b_bin  (b_bin),
    .a_bcd  (a_bcd),
    .b_bcd  (b_bcd),
    .a_ovf  (a_ovf),
    .b_ovf  (b_ovf),
    .a_blank(a_blank),
    .b_blank(b_blank),
    .a_valid(a_valid),
    .b_valid(b_valid)
  );

  int total = 0;
  int bad   = 0;

  // Model state: expected outputs plus a conversion-in-flight tracker.
  logic [15:0] m_a_bcd, m_b_bcd;
  logic        m_a_ovf, m_b_ovf;
  logic [3:0]  m_a_blank, m_b_blank;
  logic        m_a_valid, m_b_valid;
  logic        m_busy, m_chan;
  int          m_phase, m_cap;

  function automatic int sat_of(int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [15:0] bcd_of(int v);
    int s;
    s = sat_of(v);
    return {4'(s / 1000 % 10), 4'(s / 100 % 10), 4'(s / 10 % 10), 4'(s % 10)};
  endfunction

  function automatic logic [3:0] blank_of(int v);
    int s;
    logic [3:0] b;
    s = sat_of(v);
    b = 4'b0000;
    if (s < 10)   b[1] = 1'b1;
    if (s < 100)  b[2] = 1'b1;
    if (s < 1000) b[3] = 1'b1;
    return b;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_a_bcd = '0; m_b_bcd = '0; m_a_ovf = 0; m_b_ovf = 0;
      m_a_blank = '0; m_b_blank = '0; m_a_valid = 0; m_b_valid = 0;
      m_busy = 0; m_chan = 0; m_phase = 0;
    end else if (!m_busy) begin
      if (en) begin
        m_cap   = m_chan ? int'(b_bin) : int'(a_bin);
        m_busy  = 1;
        m_phase = 0;
      end
    end else begin
      m_phase++;
      if (m_phase == 17) begin
        if (m_chan) begin
          m_b_bcd = bcd_of(m_cap); m_b_ovf = (m_cap > 9999);
          m_b_blank = blank_of(m_cap); m_b_valid = 1;
        end else begin
          m_a_bcd = bcd_of(m_cap); m_a_ovf = (m_cap > 9999);
          m_a_blank = blank_of(m_cap); m_a_valid = 1;
        end
        m_chan = ~m_chan;
        m_busy = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("a_bcd", a_bcd, m_a_bcd);
    chk("b_bcd", b_bcd, m_b_bcd);
    chk("a_ovf", 16'(a_ovf), 16'(m_a_ovf));
    chk("b_ovf", 16'(b_ovf), 16'(m_b_ovf));
    chk("a_blank", 16'(a_blank), 16'(m_a_blank));
    chk("b_blank", 16'(b_blank), 16'(m_b_blank));
    chk("a_valid", 16'(a_valid), 16'(m_a_valid));
    chk("b_valid", 16'(b_valid), 16'(m_b_valid));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int          dvals[6]  = '{9999, 10000, 65535, 0, 7, 40};
  logic [15:0] dbcd[6]   = '{16'h9999, 16'h9999, 16'h9999, 16'h0000, 16'h0007, 16'h0040};
  logic        dovf[6]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [3:0]  dblank[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b1110, 4'b1110, 4'b1100};

  function automatic logic [15:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(0, 99));
      1:       return 16'($urandom_range(0, 9999));
      2:       return 16'($urandom_range(9990, 10010));
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    rst = 1; en = 0; a_bin = 0; b_bin = 0;
    run(2);
    chk("rst_a_bcd", a_bcd, 16'h0000);
    chk("rst_a_valid", 16'(a_valid), 16'h0);

    // Basic two-channel refresh.
    rst = 0; en = 1; a_bin = 1234; b_bin = 567;
    run(17);
    chk("t1_a_valid_early", 16'(a_valid), 16'h0);
    tick();
    chk("t1_a_bcd", a_bcd, 16'h1234);
    chk("t1_a_valid", 16'(a_valid), 16'h1);
    chk("t1_a_blank", 16'(a_blank), 16'h0);
    chk("t1_b_valid", 16'(b_valid), 16'h0);
    run(18);
    chk("t1_b_bcd", b_bcd, 16'h0567);
    chk("t1_b_blank", 16'(b_blank), 16'b1000);

    // Saturation and blanking boundaries on channel A.
    for (int k = 0; k < 6; k++) begin
      a_bin = 16'(dvals[k]); b_bin = 16'(dvals[k]);
      run(36);
      chk("dir_a_bcd", a_bcd, dbcd[k]);
      chk("dir_a_ovf", 16'(a_ovf), 16'(dovf[k]));
      chk("dir_a_blank", 16'(a_blank), 16'(dblank[k]));
    end

    // Input change right after LOAD must not disturb the conversion.
    a_bin = 1234;
    tick();
    a_bin = 4321;
    run(17);
    chk("cap_first", a_bcd, 16'h1234);
    run(36);
    chk("cap_second", a_bcd, 16'h4321);
    run(18);

    // Reset in the middle of a channel-A conversion.
    tick();
    run(7);
    rst = 1;
    tick();
    chk("mid_rst_a_bcd", a_bcd, 16'h0000);
    chk("mid_rst_b_valid", 16'(b_valid), 16'h0);
    rst = 0; a_bin = 321;
    run(17);
    chk("post_rst_early", 16'(a_valid), 16'h0);
    tick();
    chk("post_rst_a_bcd", a_bcd, 16'h0321);
    chk("post_rst_a_valid", 16'(a_valid), 16'h1);

    // Drop en during a channel-B conversion, then park.
    b_bin = 2468;
    tick();
    run(5);
    en = 0;
    run(12);
    chk("park_b_bcd", b_bcd, 16'h2468);
    b_bin = 1111; a_bin = 2222;
    run(100);
    chk("park_b_hold", b_bcd, 16'h2468);
    chk("park_a_hold", a_bcd, 16'h0321);
    en = 1; a_bin = 13;
    run(18);
    chk("resume_a_bcd", a_bcd, 16'h0013);
    chk("resume_a_blank", 16'(a_blank), 16'b1100);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) a_bin = rand_val();
      if ($urandom_range(0, 3) == 0) b_bin = rand_val();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
